// File: rtl/dc_wb_bridge.sv
// L1 dcache to L2 bridge: refills go straight to L2 (or are forwarded from the
// write-back buffer), dirty lines are parked in a small FIFO and drained when idle.
module dc_wb_bridge #(
    parameter int DEPTH = 2,
    parameter int AW    = 28,
    parameter int LW    = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dc_req,
    input  logic          dc_rw,
    input  logic [AW-1:0] dc_addr,
    input  logic [LW-1:0] dc_wd,
    output logic          dc_gnt,
    output logic [LW-1:0] dc_rd,
    output logic          dc_rd_en,
    output logic          wb_full,
    output logic          l2_req,
    output logic          l2_rw,
    output logic [AW-1:0] l2_addr,
    output logic [LW-1:0] l2_wd,
    input  logic          l2_ack,
    input  logic [LW-1:0] l2_rd,
    input  logic          l2_rd_vld
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WB      = 2'd3
    } state_t;

    state_t        state_reg;
    logic [AW-1:0] addr_mem [DEPTH];
    logic [LW-1:0] data_mem [DEPTH];
    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [PW:0]   count_reg;

    logic [LW-1:0] dc_rd_reg;
    logic          dc_rd_en_reg;
    logic          l2_req_reg;
    logic          l2_rw_reg;
    logic [AW-1:0] l2_addr_reg;
    logic [LW-1:0] l2_wd_reg;

    logic [DEPTH-1:0] entry_vld;
    logic [DEPTH-1:0] addr_hit;
    logic [DEPTH-1:0] wr_match;

    logic          wr_hit;
    logic [PW-1:0] wr_idx;
    logic          rd_hit;
    logic [PW-1:0] hit_idx;
    logic [LW-1:0] fwd_data;
    logic [LW-1:0] head_data;

    logic fifo_full;
    logic wr_en;
    logic rd_acc;
    logic push;
    logic pop;

    // An entry is live when its distance from the head is below the count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PW-1:0] offset;
            assign offset        = PW'(gi) - head_reg;
            assign entry_vld[gi] = ({1'b0, offset} < count_reg);
            assign addr_hit[gi]  = entry_vld[gi] && (addr_mem[gi] == dc_addr);
            // The head being drained is frozen; a write to it must take a new slot.
            assign wr_match[gi]  = addr_hit[gi] &&
                                   !((state_reg == WB) && (head_reg == PW'(gi)));
        end
    endgenerate

    always_comb begin
        wr_hit  = 1'b0;
        wr_idx  = tail_reg;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_match[i]) begin
                wr_hit = 1'b1;
                wr_idx = PW'(i);
            end
            if (addr_hit[i]) begin
                hit_idx = PW'(i);
            end
        end
    end

    assign rd_hit   = |addr_hit;
    assign fwd_data = data_mem[hit_idx];

    assign fifo_full = (count_reg == (PW+1)'(DEPTH));
    assign wr_en     = dc_req && dc_rw && !fifo_full;
    assign rd_acc    = dc_req && !dc_rw && (state_reg == IDLE);
    assign push      = wr_en && !wr_hit;
    assign pop       = (state_reg == WB) && l2_ack;

    // A coalesce onto the head in the same cycle the drain starts must reach L2.
    assign head_data = (wr_en && wr_hit && (wr_idx == head_reg)) ? dc_wd
                                                                 : data_mem[head_reg];

    assign dc_gnt   = wr_en || rd_acc;
    assign wb_full  = fifo_full;
    assign dc_rd    = dc_rd_reg;
    assign dc_rd_en = dc_rd_en_reg;
    assign l2_req   = l2_req_reg;
    assign l2_rw    = l2_rw_reg;
    assign l2_addr  = l2_addr_reg;
    assign l2_wd    = l2_wd_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            addr_mem[wr_idx] <= dc_addr;
            data_mem[wr_idx] <= dc_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            count_reg <= count_reg + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            dc_rd_reg    <= '0;
            dc_rd_en_reg <= 1'b0;
            l2_req_reg   <= 1'b0;
            l2_rw_reg    <= 1'b0;
            l2_addr_reg  <= '0;
            l2_wd_reg    <= '0;
        end else begin
            dc_rd_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rd_acc) begin
                        if (rd_hit) begin
                            dc_rd_reg    <= fwd_data;
                            dc_rd_en_reg <= 1'b1;
                        end else begin
                            state_reg   <= RD_REQ;
                            l2_req_reg  <= 1'b1;
                            l2_rw_reg   <= 1'b0;
                            l2_addr_reg <= dc_addr;
                        end
                    end else if (count_reg != '0) begin
                        state_reg   <= WB;
                        l2_req_reg  <= 1'b1;
                        l2_rw_reg   <= 1'b1;
                        l2_addr_reg <= addr_mem[head_reg];
                        l2_wd_reg   <= head_data;
                    end
                end
                RD_REQ: begin
                    if (l2_ack) begin
                        state_reg  <= RD_WAIT;
                        l2_req_reg <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (l2_rd_vld) begin
                        state_reg    <= IDLE;
                        dc_rd_reg    <= l2_rd;
                        dc_rd_en_reg <= 1'b1;
                    end
                end
                WB: begin
                    if (l2_ack) begin
                        state_reg  <= IDLE;
                        l2_req_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    l2_req_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dc_wb_bridge.sv
// Directed bench for dc_wb_bridge: reset, refill miss, fill/drain, forward hit,
// read priority over drain, and write-back coalescing.
module tb_dc_wb_bridge;

    localparam int AW = 28;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          dc_req;
    logic          dc_rw;
    logic [AW-1:0] dc_addr;
    logic [LW-1:0] dc_wd;
    logic          dc_gnt;
    logic [LW-1:0] dc_rd;
    logic          dc_rd_en;
    logic          wb_full;
    logic          l2_req;
    logic          l2_rw;
    logic [AW-1:0] l2_addr;
    logic [LW-1:0] l2_wd;
    logic          l2_ack;
    logic [LW-1:0] l2_rd;
    logic          l2_rd_vld;

    int errors = 0;
    int checks = 0;

    localparam logic [LW-1:0] D_DEAD = 128'h0123_4567_89AB_CDEF_0000_0000_0000_DEAD;
    localparam logic [LW-1:0] D_X    = 128'hFFFF_0000_FFFF_0000_1111_2222_3333_4444;
    localparam logic [LW-1:0] D_1    = 128'h1010_1010_1010_1010_1010_1010_1010_1010;
    localparam logic [LW-1:0] D_2    = 128'h2020_2020_2020_2020_2020_2020_2020_2020;
    localparam logic [LW-1:0] D_A    = 128'hAAAA_0000_0000_0000_0000_0000_0000_000A;
    localparam logic [LW-1:0] D_E    = 128'hEEEE_0000_0000_0000_0000_0000_0000_000E;
    localparam logic [LW-1:0] D_F    = 128'hFFFF_0000_0000_0000_0000_0000_0000_000F;
    localparam logic [LW-1:0] D_B    = 128'hBBBB_0000_0000_0000_0000_0000_0000_000B;
    localparam logic [LW-1:0] D_C    = 128'hCCCC_0000_0000_0000_0000_0000_0000_000C;
    localparam logic [LW-1:0] D_D    = 128'hDDDD_0000_0000_0000_0000_0000_0000_000D;

    dc_wb_bridge #(.DEPTH(2), .AW(AW), .LW(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .dc_req    (dc_req),
        .dc_rw     (dc_rw),
        .dc_addr   (dc_addr),
        .dc_wd     (dc_wd),
        .dc_gnt    (dc_gnt),
        .dc_rd     (dc_rd),
        .dc_rd_en  (dc_rd_en),
        .wb_full   (wb_full),
        .l2_req    (l2_req),
        .l2_rw     (l2_rw),
        .l2_addr   (l2_addr),
        .l2_wd     (l2_wd),
        .l2_ack    (l2_ack),
        .l2_rd     (l2_rd),
        .l2_rd_vld (l2_rd_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            $display("ok   %s: %h", tag, act);
        end
    endtask

    // Advance one clock; inputs and samples sit 1ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic rw, input logic [AW-1:0] a, input logic [LW-1:0] d);
        dc_req  = req;
        dc_rw   = rw;
        dc_addr = a;
        dc_wd   = d;
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        dc_req    = 1'b0;
        dc_rw     = 1'b0;
        dc_addr   = '0;
        dc_wd     = '0;
        l2_ack    = 1'b0;
        l2_rd     = '0;
        l2_rd_vld = 1'b0;
        repeat (3) cyc();

        // Reset state
        check("rst_dc_rd",    dc_rd, '0);
        check("rst_dc_rd_en", LW'(dc_rd_en), '0);
        check("rst_l2_req",   LW'(l2_req), '0);
        check("rst_l2_rw",    LW'(l2_rw), '0);
        check("rst_l2_addr",  LW'(l2_addr), '0);
        check("rst_l2_wd",    l2_wd, '0);
        check("rst_wb_full",  LW'(wb_full), '0);
        rst = 1'b1;
        cyc();

        // Reset in the middle of a read
        drive(1'b1, 1'b0, 28'h0000123, '0);
        check("t1_gnt", LW'(dc_gnt), 1);
        cyc();
        drive(1'b0, 1'b0, '0, '0);
        check("t1_l2_req",  LW'(l2_req), 1);
        check("t1_l2_addr", LW'(l2_addr), LW'(28'h0000123));
        l2_ack = 1'b1;
        cyc();
        l2_ack = 1'b0;
        check("t1_rdwait_req", LW'(l2_req), 0);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        check("t1_post_rst_req",  LW'(l2_req), 0);
        check("t1_post_rst_en",   LW'(dc_rd_en), 0);
        check("t1_post_rst_addr", LW'(l2_addr), 0);
        l2_rd     = D_X;
        l2_rd_vld = 1'b1;
        cyc();
        l2_rd_vld = 1'b0;
        check("t1_stale_vld_en", LW'(dc_rd_en), 0);
        check("t1_stale_vld_rd", dc_rd, '0);
        check("t1_idle_gnt_rd", LW'(l2_req), 0);

        // Refill miss with empty FIFO
        drive(1'b1, 1'b0, 28'h0ABCDEF, '0);
        check("t2_gnt", LW'(dc_gnt), 1);
        cyc();
        drive(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            check("t2_l2_req",  LW'(l2_req), 1);
            check("t2_l2_rw",   LW'(l2_rw), 0);
            check("t2_l2_addr", LW'(l2_addr), LW'(28'h0ABCDEF));
            if (i == 2) l2_ack = 1'b1;
            cyc();
        end
        l2_ack = 1'b0;
        check("t2_req_drop", LW'(l2_req), 0);
        l2_rd = D_DEAD;
        cyc();
        check("t2_wait_en0", LW'(dc_rd_en), 0);
        cyc();
        check("t2_wait_en1", LW'(dc_rd_en), 0);
        l2_rd_vld = 1'b1;
        cyc();
        l2_rd_vld = 1'b0;
        l2_rd     = '0;
        check("t2_rd_en", LW'(dc_rd_en), 1);
        check("t2_rd",    dc_rd, D_DEAD);
        cyc();
        check("t2_rd_en_pulse", LW'(dc_rd_en), 0);
        check("t2_rd_hold",     dc_rd, D_DEAD);

        // Fill the FIFO and drain it in order
        drive(1'b1, 1'b1, 28'h10, D_1);
        check("t3_gnt0", LW'(dc_gnt), 1);
        cyc();
        drive(1'b1, 1'b1, 28'h20, D_2);
        check("t3_gnt1", LW'(dc_gnt), 1);
        cyc();
        drive(1'b1, 1'b1, 28'h70, D_X);
        check("t3_full",     LW'(wb_full), 1);
        check("t3_gnt_full", LW'(dc_gnt), 0);
        check("t3_wb0_req",  LW'(l2_req), 1);
        check("t3_wb0_rw",   LW'(l2_rw), 1);
        check("t3_wb0_addr", LW'(l2_addr), LW'(28'h10));
        check("t3_wb0_wd",   l2_wd, D_1);
        drive(1'b0, 1'b0, '0, '0);
        l2_ack = 1'b1;
        cyc();
        check("t3_full_clr", LW'(wb_full), 0);
        check("t3_req_drop", LW'(l2_req), 0);
        cyc();
        check("t3_wb1_req",  LW'(l2_req), 1);
        check("t3_wb1_addr", LW'(l2_addr), LW'(28'h20));
        check("t3_wb1_wd",   l2_wd, D_2);
        cyc();
        check("t3_done_req", LW'(l2_req), 0);
        cyc();
        check("t3_empty_req", LW'(l2_req), 0);
        l2_ack = 1'b0;

        // Forward hit from the write-back buffer
        drive(1'b1, 1'b1, 28'h30, D_A);
        cyc();
        drive(1'b1, 1'b0, 28'h30, '0);
        check("t4_gnt", LW'(dc_gnt), 1);
        cyc();
        drive(1'b0, 1'b0, '0, '0);
        check("t4_rd_en",  LW'(dc_rd_en), 1);
        check("t4_rd",     dc_rd, D_A);
        check("t4_no_l2",  LW'(l2_req), 0);
        cyc();
        check("t4_rd_en_pulse", LW'(dc_rd_en), 0);
        check("t4_wb_rw",       LW'(l2_rw), 1);
        check("t4_wb_addr",     LW'(l2_addr), LW'(28'h30));
        l2_ack = 1'b1;
        cyc();
        l2_ack = 1'b0;
        check("t4_done_req", LW'(l2_req), 0);

        // Refill beats a pending drain
        drive(1'b1, 1'b1, 28'h40, D_E);
        cyc();
        drive(1'b1, 1'b0, 28'h50, '0);
        check("t5_gnt", LW'(dc_gnt), 1);
        cyc();
        drive(1'b1, 1'b0, 28'h99, '0);
        check("t5_gnt_busy", LW'(dc_gnt), 0);
        drive(1'b0, 1'b0, '0, '0);
        check("t5_rd_req",  LW'(l2_req), 1);
        check("t5_rd_rw",   LW'(l2_rw), 0);
        check("t5_rd_addr", LW'(l2_addr), LW'(28'h50));
        l2_ack = 1'b1;
        cyc();
        l2_ack    = 1'b0;
        l2_rd     = D_F;
        l2_rd_vld = 1'b1;
        cyc();
        l2_rd_vld = 1'b0;
        check("t5_rd_en",    LW'(dc_rd_en), 1);
        check("t5_rd",       dc_rd, D_F);
        check("t5_idle_req", LW'(l2_req), 0);
        cyc();
        check("t5_wb_req",  LW'(l2_req), 1);
        check("t5_wb_rw",   LW'(l2_rw), 1);
        check("t5_wb_addr", LW'(l2_addr), LW'(28'h40));
        check("t5_wb_wd",   l2_wd, D_E);
        l2_ack = 1'b1;
        cyc();
        l2_ack = 1'b0;
        check("t5_done_req", LW'(l2_req), 0);

        // Coalesce, then a write to the head being drained allocates a new slot
        drive(1'b1, 1'b1, 28'h60, D_B);
        cyc();
        drive(1'b1, 1'b1, 28'h60, D_C);
        check("t6_gnt", LW'(dc_gnt), 1);
        cyc();
        drive(1'b0, 1'b0, '0, '0);
        check("t6_not_full", LW'(wb_full), 0);
        check("t6_wb_addr",  LW'(l2_addr), LW'(28'h60));
        check("t6_wb_wd",    l2_wd, D_C);
        drive(1'b1, 1'b1, 28'h60, D_D);
        check("t6_gnt_head", LW'(dc_gnt), 1);
        cyc();
        drive(1'b0, 1'b0, '0, '0);
        check("t6_full_new", LW'(wb_full), 1);
        check("t6_wd_stable", l2_wd, D_C);
        l2_ack = 1'b1;
        cyc();
        l2_ack = 1'b0;
        check("t6_pop_req",  LW'(l2_req), 0);
        check("t6_pop_full", LW'(wb_full), 0);
        cyc();
        check("t6_wb2_addr", LW'(l2_addr), LW'(28'h60));
        check("t6_wb2_wd",   l2_wd, D_D);
        l2_ack = 1'b1;
        cyc();
        l2_ack = 1'b0;
        cyc();
        check("t6_final_req", LW'(l2_req), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
